// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared types and constants for the execute stage: ALU
//               operation codes, forwarding selects and divider FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLL   = 5'd2,
    OP_SRL   = 5'd3,
    OP_SRA   = 5'd4,
    OP_SLT   = 5'd5,
    OP_SLTU  = 5'd6,
    OP_XOR   = 5'd7,
    OP_OR    = 5'd8,
    OP_AND   = 5'd9,
    OP_PASSB = 5'd10,
    OP_MUL   = 5'd11,
    OP_DIV   = 5'd12,
    OP_DIVU  = 5'd13,
    OP_REM   = 5'd14,
    OP_REMU  = 5'd15
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_DIV  = 1'b1
  } div_state_e;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring divider, one quotient bit per clock.
//               Works on operand magnitudes and fixes signs on the way out.
//               done pulses (combinationally) on the final iteration, with
//               result valid in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            active,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import ex_pkg::*;

  localparam int            CW       = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV_CYCLES - 1);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            want_rem_q, want_rem_d;

  logic [XLEN:0]   shift_val;
  logic [XLEN:0]   diff_val;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [XLEN-1:0] a_mag, b_mag;

  assign active = (state_q == DS_DIV);
  assign last   = (cnt_q == LAST_CNT);
  assign done   = active & last & ~abort;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shift_val = {rem_q, quo_q[XLEN-1]};
    diff_val  = shift_val - {1'b0, dvsr_q};
    if (!diff_val[XLEN]) begin
      rem_nx = diff_val[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = shift_val[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Operand magnitudes and sign-corrected result of the final iteration
  always_comb begin
    a_mag  = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    b_mag  = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
    if (want_rem_q) begin
      result = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    end else begin
      result = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
    end
  end

  // FSM next state: capture operands at start, iterate, leave on last/abort
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    want_rem_d = want_rem_q;
    case (state_q)
      DS_IDLE: begin
        if (start) begin
          state_d    = DS_DIV;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = a_mag;
          dvsr_d     = b_mag;
          neg_quo_d  = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
          neg_rem_d  = is_signed & dividend[XLEN-1];
          want_rem_d = want_rem;
        end
      end
      DS_DIV: begin
        if (abort || last) begin
          state_d = DS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          rem_d = rem_nx;
          quo_d = quo_nx;
        end
      end
      default: begin
        state_d = DS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DS_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      want_rem_q <= want_rem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : RV32IM execute stage. Forwarding muxes, single-cycle ALU,
//               iterative divider with front-end stall, and the EX/MEM
//               pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      alu_op,
  input  logic            alu_src_a,
  input  logic            alu_src_b,
  input  logic [4:0]      rd_in,
  input  logic            ru_wr_in,
  input  logic            dm_wr_in,
  input  logic            dm_rd_in,
  input  logic [1:0]      control1,
  input  logic [1:0]      control2,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            ru_wr_out,
  output logic            dm_wr_out,
  output logic            dm_rd_out
);
  import ex_pkg::*;

  localparam int SHW = $clog2(XLEN);

  alu_op_e         op;
  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic            is_div, div_signed, div_rem, div_zero, div_ovf, div_special;
  logic            div_start, div_active, div_last, div_done;
  logic [XLEN-1:0] div_result;

  // Divide metadata held across the stall
  logic [4:0]      div_rd_q, div_rd_d;
  logic [2:0]      div_ctl_q, div_ctl_d;
  logic [XLEN-1:0] div_store_q, div_store_d;

  // EX/MEM register
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            ru_wr_out_q, ru_wr_out_d;
  logic            dm_wr_out_q, dm_wr_out_d;
  logic            dm_rd_out_q, dm_rd_out_d;

  assign op = alu_op_e'(alu_op);

  // Forwarding muxes (code 11 falls back to the ID/EX value) and operand select
  always_comb begin
    case (control1)
      FWD_MEM: fwd_a = fwd_mem_data;
      FWD_WB:  fwd_a = fwd_wb_data;
      default: fwd_a = rs1_data;
    endcase
    case (control2)
      FWD_MEM: fwd_b = fwd_mem_data;
      FWD_WB:  fwd_b = fwd_wb_data;
      default: fwd_b = rs2_data;
    endcase
    op_a = alu_src_a ? pc  : fwd_a;
    op_b = alu_src_b ? imm : fwd_b;
  end

  // Divide classification; special cases finish in the single-cycle path
  always_comb begin
    is_div      = is_div_op(op);
    div_signed  = (op == OP_DIV) || (op == OP_REM);
    div_rem     = (op == OP_REM) || (op == OP_REMU);
    div_zero    = (op_b == '0);
    div_ovf     = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    div_special = div_zero | div_ovf;
    div_start   = ~div_active & in_valid & is_div & ~div_special & ~flush;
  end

  // Stall while a divide is being issued or is still iterating
  assign busy = rst_n & (div_start | (div_active & ~div_last & ~flush));

  // Single-cycle ALU, including the divide special-case results
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_SLL:   alu_res = op_a << op_b[SHW-1:0];
      OP_SRL:   alu_res = op_a >> op_b[SHW-1:0];
      OP_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_PASSB: alu_res = op_b;
      OP_MUL:   alu_res = op_a * op_b;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (div_zero) begin
          alu_res = div_rem ? op_a : '1;
        end else if (div_ovf) begin
          alu_res = div_rem ? '0 : op_a;
        end
      end
      default:  alu_res = '0;
    endcase
  end

  div_unit #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .is_signed (div_signed),
    .want_rem  (div_rem),
    .dividend  (op_a),
    .divisor   (op_b),
    .active    (div_active),
    .last      (div_last),
    .done      (div_done),
    .result    (div_result)
  );

  // Capture destination/controls at issue; forwarding sources move during the stall
  always_comb begin
    div_rd_d    = div_rd_q;
    div_ctl_d   = div_ctl_q;
    div_store_d = div_store_q;
    if (div_start) begin
      div_rd_d    = rd_in;
      div_ctl_d   = {ru_wr_in, dm_wr_in, dm_rd_in};
      div_store_d = fwd_b;
    end
  end

  // EX/MEM next value: flush > divide completion > stall bubble > live op
  always_comb begin
    out_valid_d  = 1'b0;
    alu_result_d = alu_res;
    store_data_d = fwd_b;
    rd_out_d     = rd_in;
    ru_wr_out_d  = 1'b0;
    dm_wr_out_d  = 1'b0;
    dm_rd_out_d  = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (div_done) begin
      out_valid_d  = 1'b1;
      alu_result_d = div_result;
      store_data_d = div_store_q;
      rd_out_d     = div_rd_q;
      ru_wr_out_d  = div_ctl_q[2];
      dm_wr_out_d  = div_ctl_q[1];
      dm_rd_out_d  = div_ctl_q[0];
    end else if (!busy && in_valid) begin
      out_valid_d = 1'b1;
      ru_wr_out_d = ru_wr_in;
      dm_wr_out_d = dm_wr_in;
      dm_rd_out_d = dm_rd_in;
    end
  end

  // EX/MEM register and divide metadata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_out_q     <= '0;
      ru_wr_out_q  <= 1'b0;
      dm_wr_out_q  <= 1'b0;
      dm_rd_out_q  <= 1'b0;
      div_rd_q     <= '0;
      div_ctl_q    <= '0;
      div_store_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_out_q     <= rd_out_d;
      ru_wr_out_q  <= ru_wr_out_d;
      dm_wr_out_q  <= dm_wr_out_d;
      dm_rd_out_q  <= dm_rd_out_d;
      div_rd_q     <= div_rd_d;
      div_ctl_q    <= div_ctl_d;
      div_store_q  <= div_store_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign store_data = store_data_q;
  assign rd_out     = rd_out_q;
  assign ru_wr_out  = ru_wr_out_q;
  assign dm_wr_out  = dm_wr_out_q;
  assign dm_rd_out  = dm_rd_out_q;

endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32IM pipeline. It sits between the ID/EX register and the EX/MEM register and consumes the two 2-bit operand-select codes produced by the forwarding unit. It selects forwarded operands, runs the ALU, and handles DIV/DIVU/REM/REMU with an iterative 32-cycle divider that stalls the front end. It owns the EX/MEM pipeline register.

## Interface
Parameters:
- XLEN, 32, datapath width
- DIV_CYCLES, 32, divider iterations; equals XLEN

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  pipeline clock
  - rst_n  in  1  asynchronous active-low reset
- ID/EX inputs:
  - in_valid  in  1  ID/EX holds a live instruction
  - pc  in  XLEN  instruction PC
  - rs1_data, rs2_data  in  XLEN  register-file values from ID/EX
  - imm  in  XLEN  sign-extended immediate
  - alu_op  in  5  operation code (package enum)
  - alu_src_a  in  1  0 = rs1 operand, 1 = pc
  - alu_src_b  in  1  0 = rs2 operand, 1 = imm
  - rd_in  in  5  destination register
  - ru_wr_in, dm_wr_in, dm_rd_in  in  1 each  register-write, store and load controls
- Forwarding inputs:
  - control1, control2  in  2 each  forwarding selects for rs1 and rs2
  - fwd_mem_data  in  XLEN  EX/MEM ALU result
  - fwd_wb_data  in  XLEN  WB write-back data
- Control input:
  - flush  in  1  kill the instruction in EX
- Stall output:
  - busy  out  1  hold IF/ID and ID/EX and insert no new instruction
- EX/MEM register outputs:
  - out_valid  out  1  EX/MEM holds a live instruction
  - alu_result  out  XLEN  result
  - store_data  out  XLEN  forwarded rs2 value
  - rd_out  out  5
  - ru_wr_out, dm_wr_out, dm_rd_out  out  1 each

## Operation
- Forward mux, applied independently per operand:
  - 00 selects the ID/EX value.
  - 01 selects fwd_mem_data.
  - 10 selects fwd_wb_data.
  - 11 is treated as 00.
- The operand-A and operand-B muxes follow the forward mux.
- Single-cycle ops:
  - ADD, SUB, SLL, SRL, SRA (shift amount is operand B[4:0]), SLT, SLTU, XOR, OR, AND.
  - PASSB, used for LUI.
  - MUL, which returns the low XLEN bits of the product.
  - All complete in one cycle.
- Divide ops: DIV, DIVU, REM and REMU run on a restoring shift-subtract core.
  - The signed variants operate on magnitudes.
  - The quotient sign is sign(a) XOR sign(b).
  - The remainder takes the sign of the dividend.
- Divide special cases complete in 1 cycle with busy = 0:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Divider FSM, states IDLE and DIV with a 5-bit iteration counter:
  - IDLE → DIV when in_valid is set, the op is a non-special divide, and flush = 0. On that edge the forwarded operands, rd and controls are latched, because the forwarding sources keep moving during the stall.
  - In DIV, one iteration runs per edge. The edge with count = 31 loads the EX/MEM register with the result and returns to IDLE.
- busy = (IDLE & in_valid & non-special divide & ~flush) | (DIV & count ≠ 31).
- While busy = 1, each edge loads a bubble (out_valid = 0, all write enables 0) into EX/MEM.
- Bubble rules:
  - A bubble is written whenever in_valid = 0.
  - On a bubble, all write enables are forced to 0 and the data fields are don't-care.
- Flush:
  - Flush has priority over everything else.
  - In IDLE, EX/MEM takes a bubble.
  - In DIV, the divide aborts: state returns to IDLE, EX/MEM takes a bubble and busy drops in the same cycle.
- Reset:
  - All EX/MEM outputs become 0, state becomes IDLE, counter becomes 0 and busy becomes 0.
  - Reset mid-divide discards the divide.

## Timing
- Single-cycle ops: inputs in cycle T, result visible on the EX/MEM outputs in cycle T+1.
- Divide issued in cycle T:
  - busy is high in cycles T..T+31 and low in T+32.
  - The result is visible in cycle T+33.
  - ID/EX advances on the edge that ends T+32.
- busy is combinational from state and the ID/EX inputs. It has no dependency on the EX/MEM outputs, so it forms no combinational loop with the hazard logic.
- Forwarded data is sampled only at issue; later changes to fwd_* are ignored until return to IDLE.

## Structure
- Package ex_pkg holds:
  - the alu_op enum (5-bit codes for ADD through REMU),
  - the forward-select constants FWD_RF = 00, FWD_MEM = 01, FWD_WB = 10,
  - the divider state enum.
- One sub-module, div_unit, contains the iterative divider and sign correction. Its handshake is start/done, with done pulsed on the final iteration.
- The ALU and the muxes stay inline in ex_stage.

## Test plan
- ADD with control1 = 01, fwd_mem_data = 5, rs1_data = 9, rs2_data = 3, control2 = 00 → alu_result = 8 next cycle; out_valid = 1.
- SUB with control1 = 10, fwd_wb_data = 20, control2 = 01, fwd_mem_data = 7 → 13. Repeat with control1 = 11 and rs1_data = 4 → −3.
- DIV −7 / 2 issued at T, with fwd_mem_data altered during the stall → busy high for 32 cycles; quotient 0xFFFFFFFD visible at T+33. Then REM on the same operands → 0xFFFFFFFF.
- DIVU x / 0 → 0xFFFFFFFF and REM 0x80000000 / −1 → 0, each in 1 cycle with busy never asserted.
- Flush asserted 10 cycles into a divide → busy drops in that cycle and the next EX/MEM is a bubble. A following ADD then completes normally.
- rst_n asserted asynchronously mid-divide → all outputs 0 immediately and state IDLE. After release, the first instruction executes correctly.
